// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: op, register-control and state encodings shared by the shift register sequencer
package shift_seq_pkg;
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_SET   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_ROL   = 3'b110;
  localparam logic [2:0] OP_ROR   = 3'b111;
  localparam logic [1:0] CTRL_STORE = 2'b00;
  localparam logic [1:0] CTRL_LOAD  = 2'b01;
  localparam logic [1:0] CTRL_LS    = 2'b10;
  localparam logic [1:0] CTRL_RS    = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down-counter that flags the last remaining count
module seq_down_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] din,
  output logic          is_one
);
  logic [CW-1:0] cnt;
  // load has priority over decrement; the count never wraps below zero
  always_ff @(posedge clk or negedge clr)
    if (!clr) cnt <= '0;
    else if (load) cnt <= din;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign is_one = cnt == CW'(1);
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer driving one load/store/shift register; ROTATE_EN enables ROL/ROR
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [CW-1:0] cmd_cnt,
  input  logic          cmd_fill,
  input  logic [N-1:0]  cmd_data,
  input  logic [N-1:0]  reg_q,
  output logic          reg_clr,
  output logic          reg_set,
  output logic [1:0]    reg_ctrl,
  output logic          reg_ls,
  output logic          reg_rs,
  output logic [N-1:0]  reg_d,
  output logic          busy,
  output logic          done,
  output logic          err
);
`ifdef ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  state_t        state;
  logic [2:0]    op;
  logic          fill;
  logic          ls_fill;
  logic          rs_fill;
  logic          rot_l;
  logic          rot_r;
  logic          cnt_one;
  logic          accept;
  logic          unsup;
  logic          quick;
  logic          shift_next;
  logic [2:0]    sop;
  logic          sfill;
  logic [CW-1:0] cnt_c;
  logic          unused_q;
  assign accept     = cmd_valid && cmd_ready;
  assign cnt_c      = cmd_cnt > CW'(N) ? CW'(N) : cmd_cnt;
  assign unsup      = !ROT && cmd_op[2:1] == 2'b11;
  assign quick      = cmd_op == OP_NOP || unsup || (cmd_op[2] && cmd_cnt == '0);
  assign shift_next = (accept && !quick && cmd_op[2]) || (state == SHIFT && !cnt_one);
  assign sop        = accept ? cmd_op : op;
  assign sfill      = accept ? cmd_fill : fill;
  seq_down_counter #(.CW(CW)) u_cnt (
    .clk    (clk),
    .clr    (clr),
    .load   (accept),
    .dec    (state == SHIFT),
    .din    (cnt_c),
    .is_one (cnt_one)
  );
  // state sequencing with registered drive outputs; rotate feedback is folded in below
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state     <= IDLE;
      op        <= OP_NOP;
      fill      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      reg_clr   <= 1'b1;
      reg_set   <= 1'b1;
      reg_ctrl  <= CTRL_STORE;
      reg_d     <= '0;
      ls_fill   <= 1'b0;
      rs_fill   <= 1'b0;
      rot_l     <= 1'b0;
      rot_r     <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      reg_clr  <= 1'b1;
      reg_set  <= 1'b1;
      reg_ctrl <= CTRL_STORE;
      reg_d    <= '0;
      ls_fill  <= 1'b0;
      rs_fill  <= 1'b0;
      rot_l    <= 1'b0;
      rot_r    <= 1'b0;
      if (accept) begin
        op        <= cmd_op;
        fill      <= cmd_fill;
        busy      <= 1'b1;
        cmd_ready <= 1'b0;
        if (quick) begin
          state <= DONE;
          done  <= 1'b1;
          err   <= unsup;
        end else if (cmd_op[2]) begin
          state <= SHIFT;
        end else begin
          state    <= EXEC;
          reg_ctrl <= cmd_op == OP_LOAD ? CTRL_LOAD : CTRL_STORE;
          reg_d    <= cmd_op == OP_LOAD ? cmd_data : '0;
          reg_clr  <= cmd_op != OP_CLEAR;
          reg_set  <= cmd_op != OP_SET;
        end
      end else if (state == EXEC || (state == SHIFT && cnt_one)) begin
        state <= DONE;
        done  <= 1'b1;
      end else if (state == DONE) begin
        state     <= IDLE;
        busy      <= 1'b0;
        cmd_ready <= 1'b1;
      end
      if (shift_next) begin
        reg_ctrl <= sop[0] ? CTRL_RS : CTRL_LS;
        ls_fill  <= sop == OP_SHL && sfill;
        rs_fill  <= sop == OP_SHR && sfill;
        rot_l    <= ROT && sop == OP_ROL;
        rot_r    <= ROT && sop == OP_ROR;
      end
    end
  assign reg_ls   = ls_fill | (rot_l & reg_q[N-1]);
  assign reg_rs   = rs_fill | (rot_r & reg_q[0]);
  assign unused_q = ^reg_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench with a behavioural register model in the loop
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;
`ifdef ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  typedef struct {
    string      name;
    logic [3:0] q;
    int         lat;
    int         act;
    logic       err;
  } exp_t;
  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic       cmd_fill;
  logic [3:0] cmd_data;
  logic [3:0] regq = 4'b0000;
  logic       reg_clr;
  logic       reg_set;
  logic [1:0] reg_ctrl;
  logic       reg_ls;
  logic       reg_rs;
  logic [3:0] reg_d;
  logic       busy;
  logic       done;
  logic       err;
  exp_t       exp_q[$];
  exp_t       e;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         last_done = 0;
  int         act = 0;
  shift_seq_ctrl #(.N(4), .CW(3)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_fill  (cmd_fill),
    .cmd_data  (cmd_data),
    .reg_q     (regq),
    .reg_clr   (reg_clr),
    .reg_set   (reg_set),
    .reg_ctrl  (reg_ctrl),
    .reg_ls    (reg_ls),
    .reg_rs    (reg_rs),
    .reg_d     (reg_d),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (!reg_clr) regq <= 4'b0000;
    else if (!reg_set) regq <= 4'b1111;
    else if (reg_ctrl == CTRL_LOAD) regq <= reg_d;
    else if (reg_ctrl == CTRL_LS) regq <= {regq[2:0], reg_ls};
    else if (reg_ctrl == CTRL_RS) regq <= {reg_rs, regq[3:1]};
  task automatic chk(input string nm, input int a, input int x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, x);
    end
  endtask
  always @(negedge clk)
    if (!clr) act = 0;
    else begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc + 1;
        act = 0;
      end else if (busy && (reg_ctrl != CTRL_STORE || !reg_clr || !reg_set)) act++;
      if (err) chk("err_with_done", int'(done), 1);
      if (done) begin
        last_done = cyc;
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk({e.name, "_q"}, int'(regq), int'(e.q));
          chk({e.name, "_latency"}, cyc - acc_cyc, e.lat);
          chk({e.name, "_active_cycles"}, act, e.act);
          chk({e.name, "_err"}, int'(err), int'(e.err));
        end
      end
    end
  task automatic send(input string nm, input logic [2:0] op, input logic [2:0] cnt, input logic f,
                      input logic [3:0] d, input logic [3:0] eq, input int elat, input int eact,
                      input logic eerr, input bit push, input bit hold);
    int n = 0;
    exp_t x;
    x.name = nm; x.q = eq; x.lat = elat; x.act = eact; x.err = eerr;
    if (push) exp_q.push_back(x);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_fill = f; cmd_data = d;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      errors++; checks++;
      $display("FAIL %s_ready_timeout: got 0 expected 1", nm);
    end
    @(posedge clk); #1;
    if (hold) begin
      cmd_op = OP_LOAD; cmd_data = 4'b0110; n = 0;
      while (!cmd_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    cmd_valid = 1'b0;
  endtask
  initial begin
    int n;
    clr = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_cnt = 3'd0; cmd_fill = 1'b0; cmd_data = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ctrl", int'(reg_ctrl), 0);
    chk("rst_clr_pin", int'(reg_clr), 1);
    chk("rst_set_pin", int'(reg_set), 1);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", int'(cmd_ready), 1);
    send("load1010", OP_LOAD, 3'd0, 1'b0, 4'b1010, 4'b1010, 1, 1, 1'b0, 1, 0);
    send("load0011", OP_LOAD, 3'd0, 1'b0, 4'b0011, 4'b0011, 1, 1, 1'b0, 1, 0);
    send("shl2", OP_SHL, 3'd2, 1'b1, 4'b0000, 4'b1111, 2, 2, 1'b0, 1, 0);
    send("shr7_hold", OP_SHR, 3'd7, 1'b0, 4'b0000, 4'b0000, 4, 4, 1'b0, 1, 1);
    send("load1010b", OP_LOAD, 3'd0, 1'b0, 4'b1010, 4'b1010, 1, 1, 1'b0, 1, 0);
    send("ror1", OP_ROR, 3'd1, 1'b0, 4'b0000, ROT ? 4'b0101 : 4'b1010, ROT ? 1 : 0, ROT ? 1 : 0, !ROT, 1, 0);
    send("load1000", OP_LOAD, 3'd0, 1'b0, 4'b1000, 4'b1000, 1, 1, 1'b0, 1, 0);
    send("rol3", OP_ROL, 3'd3, 1'b0, 4'b0000, ROT ? 4'b0100 : 4'b1000, ROT ? 3 : 0, ROT ? 3 : 0, !ROT, 1, 0);
    send("clear", OP_CLEAR, 3'd0, 1'b0, 4'b0000, 4'b0000, 1, 1, 1'b0, 1, 0);
    send("set", OP_SET, 3'd0, 1'b0, 4'b0000, 4'b1111, 1, 1, 1'b0, 1, 0);
    chk("b2b_accept_gap", acc_cyc - last_done, 2);
    send("nop", OP_NOP, 3'd3, 1'b1, 4'b0101, 4'b1111, 0, 0, 1'b0, 1, 0);
    send("shr0", OP_SHR, 3'd0, 1'b0, 4'b0000, 4'b1111, 0, 0, 1'b0, 1, 0);
    send("shl4", OP_SHL, 3'd4, 1'b0, 4'b0000, 4'b0000, 4, 4, 1'b0, 1, 0);
    send("shl4_abort", OP_SHL, 3'd4, 1'b1, 4'b0000, 4'b0000, 0, 0, 1'b0, 0, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ctrl", int'(reg_ctrl), 0);
    chk("abort_ls", int'(reg_ls), 0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_q", int'(regq), 1);
    send("load0110", OP_LOAD, 3'd0, 1'b0, 4'b0110, 4'b0110, 1, 1, 1'b0, 1, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
